// File: rtl/mips_pkg.sv
// mips_pkg: encodings and constants shared by the MIPS32 pipeline stages.
//   - wbSel_e     : result source selected at write-back
//   - ldSize_e    : load access size
//   - LINK_OFFSET : distance from a jump-and-link PC to its return address
//   - wbEntry_t   : one buffered register-file write (flag, address, data)
package mips_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_LINK = 2'b10,
        WB_NONE = 2'b11
    } wbSel_e;

    typedef enum logic [1:0] {
        LD_B = 2'b00,
        LD_H = 2'b01,
        LD_W = 2'b10
    } ldSize_e;

    // The return address skips the branch delay slot.
    localparam logic [31:0] LINK_OFFSET = 32'd8;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } wbEntry_t;

endpackage

// File: rtl/load_align.sv
// load_align: combinational byte/half/word select and extension of a raw
// little-endian memory word. Shared with the MEM-stage forward path.
//   memData    in  32  raw memory word
//   addrLo     in  2   byte offset of the load address
//   ldSize     in  2   LD_B / LD_H / LD_W (the unused code behaves as word)
//   ldUnsigned in  1   1 = zero-extend, 0 = sign-extend
//   loadData   out 32  aligned, extended result
module load_align
    import mips_pkg::*;
(
    input  logic [31:0] memData,
    input  logic [1:0]  addrLo,
    input  logic [1:0]  ldSize,
    input  logic        ldUnsigned,
    output logic [31:0] loadData
);

    logic [7:0]  byteSel_s;
    logic [15:0] halfSel_s;
    logic [31:0] byteExt_s;
    logic [31:0] halfExt_s;

    // Pick the addressed byte (offset 0 = least significant byte).
    always_comb begin
        byteSel_s = 8'd0;
        case (addrLo)
            2'b00:   byteSel_s = memData[7:0];
            2'b01:   byteSel_s = memData[15:8];
            2'b10:   byteSel_s = memData[23:16];
            2'b11:   byteSel_s = memData[31:24];
            default: byteSel_s = 8'd0;
        endcase
    end

    // Halfword uses only addrLo[1]; a misaligned half never reaches this stage.
    always_comb begin
        if (addrLo[1]) begin
            halfSel_s = memData[31:16];
        end else begin
            halfSel_s = memData[15:0];
        end
    end

    // Extend the selected byte and halfword.
    always_comb begin
        if (ldUnsigned) begin
            byteExt_s = {24'd0, byteSel_s};
            halfExt_s = {16'd0, halfSel_s};
        end else begin
            byteExt_s = {{24{byteSel_s[7]}}, byteSel_s};
            halfExt_s = {{16{halfSel_s[15]}}, halfSel_s};
        end
    end

    // Final size mux; anything other than byte or half is a full word.
    always_comb begin
        loadData = memData;
        case (ldSize)
            LD_B:    loadData = byteExt_s;
            LD_H:    loadData = halfExt_s;
            default: loadData = memData;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: MIPS32 write-back stage. Accepts retiring instructions from MEM
// over valid/ready, forms the final result, buffers it in a small FIFO and
// drives one register-file write per granted cycle. Counts retirements.
//   clk, rst          clock (rising) and asynchronous active-high reset
//   in_valid/in_ready MEM handshake; in_ready depends on queue occupancy only
//   in_rd, in_wb_sel  destination register and result source
//   in_alu_result     ALU value
//   in_mem_data, in_addr_lo, in_ld_size, in_ld_unsigned  raw load and shape
//   in_pc             instruction PC (link result = PC + 8)
//   rf_grant          register-file write port free this cycle
//   RegWr/WrAddr/WrBack  register-file write port
//   fwd_valid         head entry holds a pending write
//   retired           retired-instruction count (wraps)
module wb_stage
    import mips_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_rd,
    input  logic [1:0]       in_wb_sel,
    input  logic [31:0]      in_alu_result,
    input  logic [31:0]      in_mem_data,
    input  logic [1:0]       in_addr_lo,
    input  logic [1:0]       in_ld_size,
    input  logic             in_ld_unsigned,
    input  logic [31:0]      in_pc,
    input  logic             rf_grant,
    output logic             RegWr,
    output logic [4:0]       WrAddr,
    output logic [31:0]      WrBack,
    output logic             fwd_valid,
    output logic [CNT_W-1:0] retired
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] FULL_COUNT = OCC_W'(DEPTH);

    wbEntry_t         queue_r [DEPTH];
    logic [PTR_W-1:0] wrPtr_r;
    logic [PTR_W-1:0] rdPtr_r;
    logic [OCC_W-1:0] count_r;
    logic [CNT_W-1:0] retired_r;

    logic [31:0] loadData_s;
    logic [31:0] result_s;
    logic        writeEn_s;
    logic        notEmpty_s;
    logic        push_s;
    logic        pop_s;
    wbEntry_t    head_s;

    load_align u_loadAlign (
        .memData    (in_mem_data),
        .addrLo     (in_addr_lo),
        .ldSize     (in_ld_size),
        .ldUnsigned (in_ld_unsigned),
        .loadData   (loadData_s)
    );

    // Result source mux; a no-write entry carries zero data.
    always_comb begin
        result_s = 32'd0;
        case (in_wb_sel)
            WB_ALU:  result_s = in_alu_result;
            WB_LOAD: result_s = loadData_s;
            WB_LINK: result_s = in_pc + LINK_OFFSET;
            default: result_s = 32'd0;
        endcase
    end

    // $0 is hard-wired, so its writes are dropped while the instruction still retires.
    assign writeEn_s  = (in_wb_sel != WB_NONE) && (in_rd != 5'd0);

    assign notEmpty_s = (count_r != '0);
    assign head_s     = queue_r[rdPtr_r];
    assign in_ready   = (count_r < FULL_COUNT);
    assign push_s     = in_valid && in_ready;
    // Entries without a write leave without waiting for the port.
    assign pop_s      = notEmpty_s && (rf_grant || !head_s.we);

    // Entry storage; written at the tail on each accepted instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                queue_r[i] <= '0;
            end
        end else if (push_s) begin
            queue_r[wrPtr_r] <= '{we: writeEn_s, rd: in_rd, data: result_s};
        end
    end

    // Pointers (wrap naturally at the power-of-two depth) and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_r <= '0;
            rdPtr_r <= '0;
            count_r <= '0;
        end else begin
            if (push_s) begin
                wrPtr_r <= wrPtr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rdPtr_r <= rdPtr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + OCC_W'(1);
                2'b01:   count_r <= count_r - OCC_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Retirement counter, one step per pop, wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_r <= '0;
        end else if (pop_s) begin
            retired_r <= retired_r + CNT_W'(1);
        end else begin
            retired_r <= retired_r;
        end
    end

    // Write-port outputs from the head entry; all zero while empty.
    always_comb begin
        WrAddr    = 5'd0;
        WrBack    = 32'd0;
        fwd_valid = 1'b0;
        if (notEmpty_s) begin
            WrAddr    = head_s.rd;
            WrBack    = head_s.data;
            fwd_valid = head_s.we;
        end else begin
            WrAddr    = 5'd0;
            WrBack    = 32'd0;
            fwd_valid = 1'b0;
        end
    end

    assign RegWr   = fwd_valid && rf_grant;
    assign retired = retired_r;

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MIPS32 write-back stage: the producer end of the register-file write interface (RegWr / write address / WrBack) that the decode stage consumes.
- Accepts retiring instructions from MEM over a valid/ready handshake and forms the final result: ALU value, aligned and extended load data, or link address.
- Buffers results in a 2-entry queue, then drives one register-file write per cycle when the write port is granted.
- Also counts retired instructions.

Parameters:
- DEPTH, 2, result-queue entries (power of two, ≥2)
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  MEM presents a retiring instruction
- in_ready  out  1  stage can accept this cycle
- in_rd  in  5  destination register
- in_wb_sel  in  2  result source: 00 ALU, 01 load, 10 link, 11 no write
- in_alu_result  in  32  ALU result
- in_mem_data  in  32  raw 32-bit memory word
- in_addr_lo  in  2  byte offset of the load address
- in_ld_size  in  2  00 byte, 01 half, 10 word
- in_ld_unsigned  in  1  1 = zero-extend, 0 = sign-extend
- in_pc  in  32  PC of the instruction
- rf_grant  in  1  register-file write port available this cycle
- RegWr  out  1  register-file write enable
- WrAddr  out  5  register-file write address
- WrBack  out  32  register-file write data
- fwd_valid  out  1  head entry holds a pending write (for hazard/forward logic)
- retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset (async, rst=1):
  - Queue emptied and count=0; retired=0.
  - RegWr=0, WrAddr=0, WrBack=0, fwd_valid=0; in_ready=1 once rst deasserts.
- Accept: a push occurs when in_valid && in_ready. in_ready = (count < DEPTH); it depends only on registered state, not on rf_grant.
- Result formation, combinational at input, stored on push:
  - ALU: in_alu_result.
  - Link: in_pc + 8, 32-bit wrap-around.
  - Load, byte: byte selected by in_addr_lo (little-endian: offset 0 = bits 7:0), sign- or zero-extended.
  - Load, half: half selected by in_addr_lo[1] (offset 0 = bits 15:0), extended; in_addr_lo[0] is ignored because misalignment is trapped upstream.
  - Load, word: in_mem_data unchanged; in_addr_lo ignored.
  - Load with in_ld_size=11: treated as word.
- Write flag, stored per entry: we = (in_wb_sel != 11) && (in_rd != 0). Writes to $0 are suppressed but the instruction still retires.
- Head/output, all registered queue state:
  - WrAddr and WrBack = head entry fields when the queue is non-empty, else 0.
  - fwd_valid = non-empty && head.we.
  - RegWr = fwd_valid && rf_grant.
- Pop: when non-empty && (rf_grant || !head.we). Entries with no write retire without needing a grant.
- Latency: an entry pushed at edge N is the head from cycle N+1 if the queue was empty; minimum 1 cycle from accept to RegWr.
- Simultaneous push and pop: allowed whenever count < DEPTH; count unchanged; FIFO order preserved.
- Full: count=DEPTH forces in_ready=0; a pop in that cycle does not admit a push in the same cycle.
- Empty: no pop, RegWr=0.
- rf_grant held low: the head stalls indefinitely, outputs stay stable, no write is duplicated.
- retired increments by 1 on every pop and wraps modulo 2^CNT_W.
- Pointers wrap modulo DEPTH.
- rst asserted mid-operation: queued entries are discarded with no partial write; RegWr drops immediately (asynchronous).

Decomposition:
- Shared package mips_pkg:
  - wb_sel encodings: WB_ALU, WB_LOAD, WB_LINK, WB_NONE.
  - ld_size encodings: LD_B, LD_H, LD_W.
  - Constant LINK_OFFSET = 8.
- One natural sub-module, load_align: purely combinational byte/half select and extend. It is reusable by the MEM-stage forward path.

Test Plan:
- Reset then ALU op: rd=5, alu=0x1234_5678, rf_grant=1 → next cycle RegWr=1, WrAddr=5, WrBack=0x12345678; retired=1.
- Loads with mem_data=0x80FF_7F01:
  - lb, offset 3 → 0xFFFFFF80.
  - lbu, offset 3 → 0x00000080.
  - lh, offset 2 → 0xFFFF80FF.
  - lhu, offset 0 → 0x00007F01.
  - lw → 0x80FF7F01.
- Link: pc=0xFFFF_FFFC, wb_sel=10, rd=31 → WrBack=0x00000004 (wrap).
- $0 and no-write: rd=0 with ALU, then wb_sel=11, rf_grant=0 → RegWr never asserts, both retire in consecutive cycles, retired += 2.
- Backpressure: rf_grant=0, push 3 writes → in_ready drops after 2 accepts. Raise rf_grant → writes emerge in order on consecutive cycles; the third is accepted one cycle after the first pop.
- Reset mid-stall: 2 entries queued, rf_grant=0, pulse rst between edges → RegWr, fwd_valid and retired go 0 immediately; no write after rst releases.
